// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demux/mux pair.
package tdm_pkg;
  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;
  localparam int NSLOT_BASE = 4;
  localparam int NSLOT_PAR  = 5;
  localparam int CTR_W      = 3;
endpackage

// File: rtl/tdm_demux4_if.sv
// Slot-stream input and channel-output bundle for tdm_demux4.
interface tdm_demux4_if #(parameter int W = 1);
  logic         en;
  logic [W-1:0] din;
  logic         frame;
  logic [W-1:0] A, B, C, D;
  logic         vld;
  logic         sync_err;
  logic         par_err;

  modport master (output en, din, frame,
                  input  A, B, C, D, vld, sync_err, par_err);
  modport slave  (input  en, din, frame,
                  output A, B, C, D, vld, sync_err, par_err);
endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot counter: wraps 0..NSLOT-1 on inc, synchronous load to 1 on restart.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int NSLOT = NSLOT_BASE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load1,
  output logic [CTR_W-1:0] slot,
  output logic             last
);
  assign last = (slot == CTR_W'(NSLOT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     slot <= '0;
    else if (load1) slot <= CTR_W'(1);
    else if (inc)   slot <= last ? '0 : slot + CTR_W'(1);
  end
endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer with frame tracking.
// Optional even-parity fifth slot enabled by TDM_DEMUX4_PARITY_EN.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);
`ifdef TDM_DEMUX4_PARITY_EN
  localparam int NSLOT = NSLOT_PAR;
`else
  localparam int NSLOT = NSLOT_BASE;
`endif
  // The final slot is consumed straight from din, so only NSLOT-1 slots are stored.
  localparam int NSHD = NSLOT - 1;

  state_t                   state;
  logic [CTR_W-1:0]         slot;
  logic                     last;
  logic [NSHD-1:0][W-1:0]   shadow;
  logic [3:0][W-1:0]        ch;
  logic [3:0][W-1:0]        frm;
  logic                     vld, sync_err;
  logic                     restart, early, missing, take;

  always_comb begin
    early   = bus.en && (state == LOCK) &&  bus.frame && (slot != '0);
    missing = bus.en && (state == LOCK) && !bus.frame && (slot == '0);
    restart = bus.en &&  bus.frame && ((state == HUNT) || (slot != '0));
    take    = bus.en && (state == LOCK) && !early && !missing;
  end

`ifdef TDM_DEMUX4_PARITY_EN
  logic par_err, par_ok;
  assign frm    = shadow;
  assign par_ok = ((shadow[0] ^ shadow[1] ^ shadow[2] ^ shadow[3] ^ bus.din) == '0);
  assign bus.par_err = par_err;
`else
  assign frm = {bus.din, shadow};
  assign bus.par_err = 1'b0;
`endif

  tdm_slot_ctr #(.NSLOT(NSLOT)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (take),
    .load1 (restart),
    .slot  (slot),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      shadow   <= '0;
      ch       <= '0;
      vld      <= 1'b0;
      sync_err <= 1'b0;
`ifdef TDM_DEMUX4_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      vld      <= 1'b0;
      sync_err <= 1'b0;
`ifdef TDM_DEMUX4_PARITY_EN
      par_err  <= 1'b0;
`endif
      if (restart) begin
        // An early frame also lands here: the stale partial frame is simply overwritten.
        shadow[0] <= bus.din;
        state     <= LOCK;
        sync_err  <= early;
      end else if (missing) begin
        sync_err <= 1'b1;
        state    <= HUNT;
      end else if (take) begin
        for (int i = 0; i < NSHD; i++)
          if (slot == CTR_W'(i)) shadow[i] <= bus.din;
        if (last) begin
`ifdef TDM_DEMUX4_PARITY_EN
          if (par_ok) begin
            vld <= 1'b1;
            ch  <= frm;
          end else begin
            par_err <= 1'b1;
          end
`else
          vld <= 1'b1;
          ch  <= frm;
`endif
        end
      end
    end
  end

  assign bus.A        = ch[0];
  assign bus.B        = ch[1];
  assign bus.C        = ch[2];
  assign bus.D        = ch[3];
  assign bus.vld      = vld;
  assign bus.sync_err = sync_err;
endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4; W=4 with parity when TDM_DEMUX4_PARITY_EN is set.
module tb_tdm_demux4;
`ifdef TDM_DEMUX4_PARITY_EN
  localparam int W = 4;
`else
  localparam int W = 1;
`endif

  typedef struct packed {
    logic [W-1:0] d, c, b, a;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdm_demux4_if #(.W(W)) bus ();
  tdm_demux4 #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int n_vld = 0, n_sync = 0, n_par = 0;
  int s_vld, s_sync, s_par;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pop on vld, count pulses, and catch any output change outside vld.
  initial begin
    exp_t cur, prev, e;
    logic pv;
    prev = '0;
    pv   = 1'b0;
    forever begin
      @(posedge clk); #1;
      cur = {bus.D, bus.C, bus.B, bus.A};
      if (rst_n) begin
        if (bus.vld) begin
          n_vld++;
          if (pv) chk("vld_double", 32'(1), 32'(0));
          if (q.size() == 0) chk("vld_unexpected", 32'(1), 32'(0));
          else begin
            e = q.pop_front();
            chk("A", 32'(bus.A), 32'(e.a));
            chk("B", 32'(bus.B), 32'(e.b));
            chk("C", 32'(bus.C), 32'(e.c));
            chk("D", 32'(bus.D), 32'(e.d));
          end
        end else if (cur != prev) chk("hold", 32'(cur), 32'(prev));
        if (bus.sync_err) n_sync++;
        if (bus.par_err)  n_par++;
      end
      pv   = bus.vld;
      prev = cur;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic f, input int gap);
    bus.en = 1'b1; bus.din = d; bus.frame = f;
    @(negedge clk);
    bus.en = 1'b0; bus.din = '0; bus.frame = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] a, b, c, d, input int gap);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.d = d;
    q.push_back(e);
    send(a, 1'b1, gap);
    send(b, 1'b0, gap);
    send(c, 1'b0, gap);
`ifdef TDM_DEMUX4_PARITY_EN
    send(d, 1'b0, gap);
    chk("vld_early", 32'(bus.vld), 32'(0));
    send(a ^ b ^ c ^ d, 1'b0, 0);
`else
    chk("vld_early", 32'(bus.vld), 32'(0));
    send(d, 1'b0, 0);
`endif
    chk("vld_edge", 32'(bus.vld), 32'(1));
  endtask

  task automatic snap();
    s_vld = n_vld; s_sync = n_sync; s_par = n_par;
  endtask

  initial begin
    bus.en = 1'b0; bus.din = '0; bus.frame = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_A", 32'(bus.A), 32'(0));
    chk("rst_D", 32'(bus.D), 32'(0));
    chk("rst_vld", 32'(bus.vld), 32'(0));
    chk("rst_sync", 32'(bus.sync_err), 32'(0));
    chk("rst_par", 32'(bus.par_err), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Clean frame, then the same frame with two idle cycles between slots
    snap();
    send_frame(W'(1), W'(0), W'(1), W'(1), 0);
    @(negedge clk);
    chk("vld_one_cycle", 32'(bus.vld), 32'(0));
    send_frame(W'(1), W'(0), W'(1), W'(1), 2);
    @(negedge clk);
    chk("clean_vld_cnt", 32'(n_vld - s_vld), 32'(2));
    chk("clean_sync_cnt", 32'(n_sync - s_sync), 32'(0));

    // Early frame at slot 2
    snap();
    send(W'(0), 1'b1, 0);
    send(W'(1), 1'b0, 0);
    send_frame(W'(1), W'(0), W'(1), W'(0), 0);
    @(negedge clk);
    chk("early_sync_cnt", 32'(n_sync - s_sync), 32'(1));
    chk("early_vld_cnt", 32'(n_vld - s_vld), 32'(1));

    // Missing frame at slot 0, HUNT ignores frame=0, then resync
    snap();
    send(W'(1), 1'b0, 0);
    chk("miss_sync", 32'(bus.sync_err), 32'(1));
    send(W'(1), 1'b0, 0);
    chk("miss_sync_once", 32'(bus.sync_err), 32'(0));
    send(W'(0), 1'b0, 1);
    send_frame(W'(0), W'(1), W'(1), W'(0), 1);
    @(negedge clk);
    chk("miss_sync_cnt", 32'(n_sync - s_sync), 32'(1));
    chk("miss_vld_cnt", 32'(n_vld - s_vld), 32'(1));

    // Asynchronous reset mid-frame
    send(W'(1), 1'b1, 0);
    send(W'(1), 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_B", 32'(bus.B), 32'(0));
    chk("mid_rst_C", 32'(bus.C), 32'(0));
    chk("mid_rst_vld", 32'(bus.vld), 32'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    snap();
    for (int i = 0; i < 5; i++) send(W'(1), 1'b0, 0);
    @(negedge clk);
    chk("post_rst_vld_cnt", 32'(n_vld - s_vld), 32'(0));
    chk("post_rst_sync_cnt", 32'(n_sync - s_sync), 32'(0));

    // Reset while vld is high clears it without a clock edge
    send_frame(W'(1), W'(1), W'(1), W'(1), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("vld_rst", 32'(bus.vld), 32'(0));
    chk("vld_rst_A", 32'(bus.A), 32'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random frames with random gaps
    for (int k = 0; k < 8; k++)
      send_frame(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                 int'($urandom_range(0, 2)));

`ifdef TDM_DEMUX4_PARITY_EN
    send_frame(W'(1), W'(2), W'(4), W'(8), 0);
    chk("par_A", 32'(bus.A), 32'(1));
    chk("par_D", 32'(bus.D), 32'(8));
    snap();
    send(W'(1), 1'b1, 0);
    send(W'(2), 1'b0, 0);
    send(W'(4), 1'b0, 0);
    send(W'(8), 1'b0, 0);
    send(W'(14), 1'b0, 0);
    chk("par_err", 32'(bus.par_err), 32'(1));
    chk("par_bad_vld", 32'(bus.vld), 32'(0));
    chk("par_hold_D", 32'(bus.D), 32'(8));
    @(negedge clk);
    chk("par_err_cnt", 32'(n_par - s_par), 32'(1));
    send_frame(W'(3), W'(5), W'(7), W'(9), 0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'(0));
`ifndef TDM_DEMUX4_PARITY_EN
    chk("par_never", 32'(n_par), 32'(0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
